// File: rtl/hazard_controller_if.sv
// ID/EX/WB-side signals of the hazard controller: instruction fields in, interlock/flush controls and stats out.
interface hazard_controller_if #(
  parameter int NREG_W = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [NREG_W-1:0] id_rs_addr;
  logic [NREG_W-1:0] id_rt_addr;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_reg_write;
  logic [NREG_W-1:0] id_dest_addr;
  logic              id_jump;
  logic              ex_branch_taken;
  logic              RegWriteW;
  logic [NREG_W-1:0] wb_addr;
  logic              stall_F;
  logic              stall_D;
  logic              flush_D;
  logic              flush_E;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;
  logic              sb_error;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_reg_write,
           id_dest_addr, id_jump, ex_branch_taken, RegWriteW, wb_addr,
    input  stall_F, stall_D, flush_D, flush_E, stall_count, flush_count, sb_error
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_reg_write,
           id_dest_addr, id_jump, ex_branch_taken, RegWriteW, wb_addr,
    output stall_F, stall_D, flush_D, flush_E, stall_count, flush_count, sb_error
  );
endinterface

// File: rtl/hazard_controller.sv
// Interlock/flush controller for a non-forwarding 5-stage MIPS pipe: a 3-deep destination
// scoreboard (EX, MEM, WB) drives RAW stalls; jumps and taken branches squash wrong-path work.
module hazard_controller #(
  parameter int CNT_W  = 16,
  parameter int NREG_W = 5
) (
  input logic                CLK,
  input logic                RSTn,
  hazard_controller_if.slave hz
);
  localparam int STAGES = 3;

  typedef struct packed {
    logic              v;
    logic [NREG_W-1:0] addr;
  } sb_ent_t;

  // Slot 0 = EX, 1 = MEM, 2 = WB; shifts one slot per edge.
  sb_ent_t [STAGES-1:0] sb_q, sb_d;
  sb_ent_t              ex_ent;
  logic [CNT_W-1:0]     stall_count_q, stall_count_d;
  logic [CNT_W-1:0]     flush_count_q, flush_count_d;
  logic                 sb_error_q, sb_error_d;
  logic                 rs_hit, rt_hit, hazard;
  logic                 stall_c, flush_d_c, flush_e_c;
  logic                 wb_wr, wb_bad;

  function automatic logic in_flight(input logic [NREG_W-1:0] a, input sb_ent_t [STAGES-1:0] sb);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < STAGES; i++) hit |= sb[i].v & (sb[i].addr == a);
    return hit & (a != '0);
  endfunction

  always_comb begin
    rs_hit    = in_flight(hz.id_rs_addr, sb_q);
    rt_hit    = in_flight(hz.id_rt_addr, sb_q);
    hazard    = hz.id_valid & ((hz.id_uses_rs & rs_hit) | (hz.id_uses_rt & rt_hit));
    stall_c   = 1'b0;
    flush_d_c = 1'b0;
    flush_e_c = 1'b0;
    // A taken branch makes the ID instruction wrong-path, so it beats any interlock.
    if (hz.ex_branch_taken) begin
      flush_d_c = 1'b1;
      flush_e_c = 1'b1;
    end else if (hazard) begin
      stall_c   = 1'b1;
      flush_e_c = 1'b1;
    end else if (hz.id_valid & hz.id_jump) begin
      flush_d_c = 1'b1;
    end
    if (!RSTn) begin
      stall_c   = 1'b0;
      flush_d_c = 1'b0;
      flush_e_c = 1'b0;
    end
  end

  always_comb begin
    ex_ent.v    = ~flush_e_c & hz.id_valid & hz.id_reg_write & (hz.id_dest_addr != '0);
    ex_ent.addr = flush_e_c ? '0 : hz.id_dest_addr;
    sb_d        = {sb_q[STAGES-2:0], ex_ent};

    stall_count_d = (stall_c && stall_count_q != '1) ? stall_count_q + CNT_W'(1) : stall_count_q;
    flush_count_d = (flush_d_c && flush_count_q != '1) ? flush_count_q + CNT_W'(1) : flush_count_q;

    // A write to r0 in WB is architecturally a no-op, so it is not treated as a write.
    wb_wr      = hz.RegWriteW & (hz.wb_addr != '0);
    wb_bad     = (sb_q[STAGES-1].v != wb_wr) |
                 (sb_q[STAGES-1].v & (hz.wb_addr != sb_q[STAGES-1].addr));
    sb_error_d = sb_error_q | wb_bad;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sb_q          <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
      sb_error_q    <= 1'b0;
    end else begin
      sb_q          <= sb_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
      sb_error_q    <= sb_error_d;
    end
  end

  assign hz.stall_F     = stall_c;
  assign hz.stall_D     = stall_c;
  assign hz.flush_D     = flush_d_c;
  assign hz.flush_E     = flush_e_c;
  assign hz.stall_count = stall_count_q;
  assign hz.flush_count = flush_count_q;
  assign hz.sb_error    = sb_error_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus a random pipeline stream, checked
// cycle-by-cycle by a queue-fed monitor against a register-history reference model.
module tb_hazard_controller;
  localparam int NW   = 5;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct {
    bit sF, sD, fD, fE, err;
    int sc, fc;
  } exp_t;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  hazard_controller_if #(.NREG_W(NW), .CNT_W(CW)) hif ();
  hazard_controller #(.CNT_W(CW), .NREG_W(NW)) dut (.CLK(CLK), .RSTn(RSTn), .hz(hif));

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  // Reference state: destination register in EX/MEM/WB, 0 meaning nothing pending.
  int m_ex, m_mem, m_wb, m_sc, m_fc;
  bit m_err;

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit pending(int a);
    return a != 0 && (a == m_ex || a == m_mem || a == m_wb);
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stall_F", hif.stall_F, e.sF);
      chk("stall_D", hif.stall_D, e.sD);
      chk("flush_D", hif.flush_D, e.fD);
      chk("flush_E", hif.flush_E, e.fE);
      chk("stall_count", hif.stall_count, e.sc);
      chk("flush_count", hif.flush_count, e.fc);
      chk("sb_error", hif.sb_error, e.err);
    end
  end

  task automatic set_id(bit v, int rs, int rt, bit urs, bit urt, bit rw, int dest, bit j, bit br);
    hif.id_valid        = v;
    hif.id_rs_addr      = NW'(rs);
    hif.id_rt_addr      = NW'(rt);
    hif.id_uses_rs      = urs;
    hif.id_uses_rt      = urt;
    hif.id_reg_write    = rw;
    hif.id_dest_addr    = NW'(dest);
    hif.id_jump         = j;
    hif.ex_branch_taken = br;
  endtask

  // Called just after a rising edge with ID inputs set; returns the expected controls.
  task automatic step(input bit auto_wb, output exp_t e);
    bit hz, wb_eff;
    if (auto_wb) begin
      hif.RegWriteW = (m_wb != 0);
      hif.wb_addr   = (m_wb != 0) ? NW'(m_wb) : NW'($urandom_range(0, 31));
    end
    e = '{default: 0};
    if (RSTn) begin
      hz = hif.id_valid && ((hif.id_uses_rs && pending(int'(hif.id_rs_addr))) ||
                            (hif.id_uses_rt && pending(int'(hif.id_rt_addr))));
      if (hif.ex_branch_taken) begin
        e.fD = 1; e.fE = 1;
      end else if (hz) begin
        e.sF = 1; e.sD = 1; e.fE = 1;
      end else if (hif.id_valid && hif.id_jump) begin
        e.fD = 1;
      end
      e.sc = m_sc; e.fc = m_fc; e.err = m_err;
    end
    q.push_back(e);
    @(posedge CLK);
    if (RSTn) begin
      wb_eff = hif.RegWriteW && hif.wb_addr != 0;
      if ((m_wb != 0) != wb_eff || (m_wb != 0 && int'(hif.wb_addr) != m_wb)) m_err = 1;
      if (e.sD && m_sc < MAXC) m_sc++;
      if (e.fD && m_fc < MAXC) m_fc++;
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (!e.fE && hif.id_valid && hif.id_reg_write) ? int'(hif.id_dest_addr) : 0;
    end
    #1;
  endtask

  task automatic tick();
    exp_t e;
    step(1'b1, e);
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    m_ex = 0; m_mem = 0; m_wb = 0; m_sc = 0; m_fc = 0; m_err = 0;
    tick();
    RSTn = 1'b1;
  endtask

  task automatic writer(int d);
    set_id(1, 0, 0, 0, 0, 1, d, 0, 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t prev;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    hif.RegWriteW = 1'b0;
    hif.wb_addr   = '0;
    @(posedge CLK);
    #1;

    // Reset asserted mid-stall, then released with an empty scoreboard.
    do_reset();
    writer(5);
    set_id(1, 5, 0, 1, 0, 1, 6, 0, 0);
    tick();
    RSTn = 1'b0;
    m_ex = 0; m_mem = 0; m_wb = 0; m_sc = 0; m_fc = 0; m_err = 0;
    #1;
    chk("rst_stall_D", hif.stall_D, 0);
    chk("rst_stall_count", hif.stall_count, 0);
    tick();
    RSTn = 1'b1;
    #1;
    chk("rst_release_nostall", hif.stall_D, 0);
    tick();

    // Back-to-back RAW: three stall cycles.
    do_reset();
    writer(5);
    set_id(1, 5, 0, 1, 1, 1, 6, 0, 0);
    repeat (4) tick();
    chk("raw_b2b_stalls", hif.stall_count, 3);

    // One independent instruction between writer and reader: two stalls; r0 never stalls.
    do_reset();
    writer(7);
    set_id(1, 1, 2, 1, 1, 1, 9, 0, 0);
    tick();
    set_id(1, 7, 0, 0, 1, 1, 10, 0, 0);
    hif.id_rt_addr = NW'(7);
    repeat (3) tick();
    chk("raw_gap1_stalls", hif.stall_count, 2);
    writer(0);
    set_id(1, 0, 0, 1, 1, 1, 11, 0, 0);
    tick();
    chk("r0_no_stall", hif.stall_count, 2);

    // Jump flushes once; jr on a fresh r8 waits three cycles and then flushes.
    do_reset();
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    chk("jump_flush_count", hif.flush_count, 1);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    writer(8);
    set_id(1, 8, 0, 1, 0, 0, 0, 1, 0);
    repeat (4) tick();
    chk("jr_stall_count", hif.stall_count, 3);
    chk("jr_flush_count", hif.flush_count, 2);

    // Taken branch overrides a live hazard.
    do_reset();
    writer(5);
    set_id(1, 5, 0, 1, 0, 0, 0, 0, 1);
    #1;
    chk("br_override_stall_D", hif.stall_D, 0);
    chk("br_override_flush_E", hif.flush_E, 1);
    tick();
    chk("br_override_stall_count", hif.stall_count, 0);
    chk("br_override_flush_count", hif.flush_count, 1);

    // Counter saturation.
    do_reset();
    repeat (86) begin
      writer(5);
      set_id(1, 5, 0, 1, 0, 0, 0, 0, 0);
      repeat (4) tick();
    end
    chk("stall_count_sat", hif.stall_count, MAXC);
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (MAXC + 5) tick();
    chk("flush_count_sat", hif.flush_count, MAXC);

    // WB write with nothing tracked in WB sets the sticky error.
    do_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    hif.RegWriteW = 1'b1;
    hif.wb_addr   = NW'(9);
    step(1'b0, prev);
    repeat (4) tick();
    chk("sb_error_sticky", hif.sb_error, 1);
    do_reset();
    chk("sb_error_cleared", hif.sb_error, 0);

    // Random pipeline stream: stalled instructions are held, flushed slots become bubbles.
    prev = '{default: 0};
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        prev = '{default: 0};
        continue;
      end
      if (!prev.sD) begin
        if (prev.fD)
          set_id(0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), 0, 0);
        else
          set_id($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 9) == 0, 0);
      end
      hif.ex_branch_taken = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) begin
        hif.RegWriteW = (m_wb == 0);
        hif.wb_addr   = NW'($urandom_range(1, 31));
        step(1'b0, prev);
      end else begin
        step(1'b1, prev);
      end
    end

    @(negedge CLK);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
